// File: rtl/vip_ycbcr_pkg.sv
// Shared constants for the RGB->YCbCr converter: matrix coefficients for
// BT.601 / BT.709, mode encoding and a generic unsigned saturation helper.
package vip_ycbcr_pkg;

    localparam logic MODE_BT601 = 1'b0;
    localparam logic MODE_BT709 = 1'b1;

    // Coefficients are 8-bit magnitudes; one sign bit added so 128 fits.
    localparam int COEF_W = 9;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef struct packed {
        coef_t yr;
        coef_t yg;
        coef_t yb;
        coef_t cbr;
        coef_t cbg;
        coef_t cbb;
        coef_t crr;
        coef_t crg;
        coef_t crb;
    } coef_set_t;

    localparam coef_set_t COEF_BT601 = '{
        yr:  9'sd77,  yg:  9'sd150,  yb:  9'sd29,
        cbr: -9'sd43, cbg: -9'sd85,  cbb: 9'sd128,
        crr: 9'sd128, crg: -9'sd107, crb: -9'sd21
    };

    localparam coef_set_t COEF_BT709 = '{
        yr:  9'sd54,  yg:  9'sd183,  yb:  9'sd19,
        cbr: -9'sd29, cbg: -9'sd99,  cbb: 9'sd128,
        crr: 9'sd128, crg: -9'sd116, crb: -9'sd12
    };

    function automatic coef_set_t coef_sel(input logic mode);
        return (mode == MODE_BT709) ? COEF_BT709 : COEF_BT601;
    endfunction

    // Clamp a signed value into [0, 2^dw-1]; dw is at most 12 here.
    function automatic logic [15:0] saturate(input logic signed [31:0] value, input int dw);
        logic signed [31:0] max_v;
        max_v = (32'sd1 <<< dw) - 32'sd1;
        if (value < 32'sd0) begin
            return 16'd0;
        end
        if (value > max_v) begin
            return max_v[15:0];
        end
        return value[15:0];
    endfunction

endpackage

// File: rtl/vip_ycbcr_stats.sv
// Per-frame luma accumulator: sums Y and counts valid pixels, publishes both
// on the rising edge of the (delayed) vsync and restarts from zero.
module vip_ycbcr_stats #(
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync_i,
    input  logic             clken_i,
    input  logic [DW-1:0]    y_i,
    output logic             stat_valid_o,
    output logic [DW+21:0]   stat_luma_sum_o,
    output logic [21:0]      stat_pix_cnt_o
);

    localparam int SUM_W = DW + 22;

    logic             vsync_q;
    logic             vsync_rise;
    logic [SUM_W-1:0] sum_q, sum_d, sum_inc;
    logic [SUM_W:0]   sum_ext;
    logic [21:0]      cnt_q, cnt_d, cnt_inc;
    logic             valid_q;
    logic [SUM_W-1:0] stat_sum_q;
    logic [21:0]      stat_cnt_q;

    assign vsync_rise = vsync_i & ~vsync_q;

    always_comb begin
        sum_ext = {1'b0, sum_q} + (SUM_W+1)'(y_i);
        // Both accumulators stick at all-ones instead of wrapping.
        sum_inc = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 22'd1;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        if (vsync_rise) begin
            sum_d = clken_i ? SUM_W'(y_i) : '0;
            cnt_d = clken_i ? 22'd1 : 22'd0;
        end else if (clken_i) begin
            sum_d = sum_inc;
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q    <= 1'b0;
            sum_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            stat_sum_q <= '0;
            stat_cnt_q <= '0;
        end else begin
            vsync_q <= vsync_i;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            valid_q <= vsync_rise;
            if (vsync_rise) begin
                stat_sum_q <= sum_q;
                stat_cnt_q <= cnt_q;
            end
        end
    end

    assign stat_valid_o    = valid_q;
    assign stat_luma_sum_o = stat_sum_q;
    assign stat_pix_cnt_o  = stat_cnt_q;

endmodule

// File: rtl/vip_rgb2ycbcr_pipe.sv
// Three-stage streaming RGB->YCbCr444 converter with frame-latched BT.601/709
// selection and luma offset. Define VIP_YCBCR_STATS_EN for per-frame luma stats.
module vip_rgb2ycbcr_pipe
    import vip_ycbcr_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                per_frame_vsync,
    input  logic                per_frame_clken,
    input  logic [AW-1:0]       per_frame_addr,
    input  logic [DW-1:0]       per_img_red,
    input  logic [DW-1:0]       per_img_green,
    input  logic [DW-1:0]       per_img_blue,
    input  logic                cfg_mode,
    input  logic signed [DW:0]  cfg_luma_ofs,
    output logic                post_frame_vsync,
    output logic                post_frame_clken,
    output logic [AW-1:0]       post_frame_addr,
    output logic [DW-1:0]       post_img_Y,
    output logic [DW-1:0]       post_img_Cb,
    output logic [DW-1:0]       post_img_Cr,
    output logic                stat_valid,
    output logic [DW+21:0]      stat_luma_sum,
    output logic [21:0]         stat_pix_cnt
);

    localparam int STAGES = 3;
    localparam int SW     = DW + 10;
    localparam logic signed [SW-1:0] CHROMA_BIAS = SW'(longint'(1) << (DW + 7));

    function automatic logic signed [SW-1:0] mul(input logic [DW-1:0] c, input coef_t k);
        return $signed({{(SW-DW){1'b0}}, c}) * SW'(k);
    endfunction

    function automatic logic [DW-1:0] sat_dw(input logic signed [SW-1:0] v);
        return DW'(saturate(32'(v), DW));
    endfunction

    logic      vsync_in_q;
    logic      mode_q, mode_d;
    coef_set_t k;

    // A coincident vsync fall already applies the new matrix to that pixel.
    assign mode_d = (vsync_in_q & ~per_frame_vsync) ? cfg_mode : mode_q;
    assign k      = coef_sel(mode_d);

    logic signed [SW-1:0] prod_p1_d [9];
    logic signed [SW-1:0] prod_p1_q [9];
    logic signed [SW-1:0] y_sum_p2_d, cb_sum_p2_d, cr_sum_p2_d;
    logic signed [SW-1:0] y_sum_p2_q, cb_sum_p2_q, cr_sum_p2_q;
    logic [DW-1:0]        y_p3_d, cb_p3_d, cr_p3_d;
    logic [DW-1:0]        y_p3_q, cb_p3_q, cr_p3_q;
    logic [STAGES-1:0]    vsync_q, clken_q;
    logic [AW-1:0]        addr_q [STAGES];

    // S1: nine component x coefficient products
    always_comb begin
        prod_p1_d[0] = mul(per_img_red,   k.yr);
        prod_p1_d[1] = mul(per_img_green, k.yg);
        prod_p1_d[2] = mul(per_img_blue,  k.yb);
        prod_p1_d[3] = mul(per_img_red,   k.cbr);
        prod_p1_d[4] = mul(per_img_green, k.cbg);
        prod_p1_d[5] = mul(per_img_blue,  k.cbb);
        prod_p1_d[6] = mul(per_img_red,   k.crr);
        prod_p1_d[7] = mul(per_img_green, k.crg);
        prod_p1_d[8] = mul(per_img_blue,  k.crb);
    end

    // S2: signed sums with chroma bias
    always_comb begin
        y_sum_p2_d  = prod_p1_q[0] + prod_p1_q[1] + prod_p1_q[2];
        cb_sum_p2_d = prod_p1_q[3] + prod_p1_q[4] + prod_p1_q[5] + CHROMA_BIAS;
        cr_sum_p2_d = prod_p1_q[6] + prod_p1_q[7] + prod_p1_q[8] + CHROMA_BIAS;
    end

    // S3: truncating shift, live luma offset, clamp to component range
    always_comb begin
        y_p3_d  = sat_dw((y_sum_p2_q >>> 8) + SW'(cfg_luma_ofs));
        cb_p3_d = sat_dw(cb_sum_p2_q >>> 8);
        cr_p3_d = sat_dw(cr_sum_p2_q >>> 8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_in_q  <= 1'b0;
            mode_q      <= MODE_BT601;
            for (int i = 0; i < 9; i++) begin
                prod_p1_q[i] <= '0;
            end
            y_sum_p2_q  <= '0;
            cb_sum_p2_q <= '0;
            cr_sum_p2_q <= '0;
            y_p3_q      <= '0;
            cb_p3_q     <= '0;
            cr_p3_q     <= '0;
            vsync_q     <= '0;
            clken_q     <= '0;
            for (int i = 0; i < STAGES; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vsync_in_q  <= per_frame_vsync;
            mode_q      <= mode_d;
            for (int i = 0; i < 9; i++) begin
                prod_p1_q[i] <= prod_p1_d[i];
            end
            y_sum_p2_q  <= y_sum_p2_d;
            cb_sum_p2_q <= cb_sum_p2_d;
            cr_sum_p2_q <= cr_sum_p2_d;
            y_p3_q      <= y_p3_d;
            cb_p3_q     <= cb_p3_d;
            cr_p3_q     <= cr_p3_d;
            vsync_q     <= {vsync_q[STAGES-2:0], per_frame_vsync};
            clken_q     <= {clken_q[STAGES-2:0], per_frame_clken};
            addr_q[0]   <= per_frame_addr;
            for (int i = 1; i < STAGES; i++) begin
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign post_frame_vsync = vsync_q[STAGES-1];
    assign post_frame_clken = clken_q[STAGES-1];
    assign post_frame_addr  = addr_q[STAGES-1];
    assign post_img_Y       = y_p3_q;
    assign post_img_Cb      = cb_p3_q;
    assign post_img_Cr      = cr_p3_q;

`ifdef VIP_YCBCR_STATS_EN
    vip_ycbcr_stats #(
        .DW(DW)
    ) u_stats (
        .clk             (clk),
        .rst             (rst),
        .vsync_i         (post_frame_vsync),
        .clken_i         (post_frame_clken),
        .y_i             (post_img_Y),
        .stat_valid_o    (stat_valid),
        .stat_luma_sum_o (stat_luma_sum),
        .stat_pix_cnt_o  (stat_pix_cnt)
    );
`else
    assign stat_valid    = 1'b0;
    assign stat_luma_sum = '0;
    assign stat_pix_cnt  = '0;
`endif

endmodule
